scr1_imem_tcm_bridge: RTL and testbench



---
 rtl/scr1_imem_tcm_bridge.sv | 163 ++++++++++++++++
 tb/tb_scr1_imem_tcm_bridge.sv | 307 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/scr1_imem_tcm_bridge.sv
// ---------------------------------------------------------------------------
// scr1_memif_pkg / scr1_imem_tcm_bridge
//
// Purpose:
//   Instruction-side memory target placed directly downstream of the core's
//   IMEM request port. Core fetches arrive over the SCR1 memif req/ack/resp
//   handshake. They are mapped onto a single-ported synchronous TCM SRAM
//   that has a fixed read latency and a grant shared with other masters.
//   Illegal fetches (writes, misaligned addresses, addresses outside the TCM
//   window) are acked at once without touching the SRAM. They come back as
//   in-order error responses. The first faulting address is latched for
//   software. One fetch per cycle is sustained, with up to READ_LAT fetches
//   in flight.
//
// Ports:
//   clk, rst              core clock, asynchronous active-high reset
//   core2imem_req_i       fetch request
//   core2imem_cmd_i       command (only reads are legal)
//   core2imem_addr_i      byte address
//   imem2core_req_ack_o   request accepted this cycle (combinational)
//   imem2core_rdata_o     fetch data (zero unless an OK response)
//   imem2core_resp_o      NOTRDY / RDY_OK / RDY_ER
//   sram_req_o            SRAM read request (combinational)
//   sram_addr_o           SRAM word address
//   sram_gnt_i            shared SRAM port granted this cycle
//   sram_rdata_i          SRAM data, valid READ_LAT cycles after a grant
//   err_vld_o             sticky error-seen flag
//   err_addr_o            address of the first erroring request
//   err_clr_i             clears err_vld_o (a same-cycle capture wins)
// ---------------------------------------------------------------------------

package scr1_memif_pkg;

  typedef enum logic {
    SCR1_MEM_CMD_RD = 1'b0,
    SCR1_MEM_CMD_WR = 1'b1
  } type_scr1_mem_cmd_e;

  typedef enum logic [1:0] {
    SCR1_MEM_RESP_NOTRDY = 2'b00,
    SCR1_MEM_RESP_RDY_OK = 2'b01,
    SCR1_MEM_RESP_RDY_ER = 2'b10
  } type_scr1_mem_resp_e;

endpackage

module scr1_imem_tcm_bridge
  import scr1_memif_pkg::*;
#(
  parameter int                     IMEM_AWIDTH = 32,
  parameter int                     IMEM_DWIDTH = 32,
  parameter int                     TCM_AWIDTH  = 14,
  parameter logic [IMEM_AWIDTH-1:0] TCM_BASE    = 32'hF000_0000,
  parameter int                     READ_LAT    = 1
) (
  input  logic                   clk,
  input  logic                   rst,

  input  logic                   core2imem_req_i,
  input  type_scr1_mem_cmd_e     core2imem_cmd_i,
  input  logic [IMEM_AWIDTH-1:0] core2imem_addr_i,
  output logic                   imem2core_req_ack_o,
  output logic [IMEM_DWIDTH-1:0] imem2core_rdata_o,
  output type_scr1_mem_resp_e    imem2core_resp_o,

  output logic                   sram_req_o,
  output logic [TCM_AWIDTH-1:0]  sram_addr_o,
  input  logic                   sram_gnt_i,
  input  logic [IMEM_DWIDTH-1:0] sram_rdata_i,

  output logic                   err_vld_o,
  output logic [IMEM_AWIDTH-1:0] err_addr_o,
  input  logic                   err_clr_i
);

  // First address bit above the TCM window; everything from here up must
  // match the window base for a fetch to land in the TCM.
  localparam int WIN_LSB = TCM_AWIDTH + 2;

  logic                   w_isRead;
  logic                   w_aligned;
  logic                   w_inWindow;
  logic                   w_legal;
  logic                   w_accept;
  logic                   w_errCapture;

  logic [READ_LAT-1:0]    r_pipeVld;
  logic [READ_LAT-1:0]    r_pipeErr;
  logic                   r_errVld;
  logic [IMEM_AWIDTH-1:0] r_errAddr;

  // Request decode and handshake. Illegal requests never reach the SRAM, so
  // they do not wait for the shared grant and are acked immediately. Nothing
  // is remembered about a denied request: the core holds it stable and we
  // simply re-evaluate it next cycle.
  always_comb begin
    w_isRead     = (core2imem_cmd_i == SCR1_MEM_CMD_RD);
    w_aligned    = (core2imem_addr_i[1:0] == 2'b00);
    w_inWindow   = (core2imem_addr_i[IMEM_AWIDTH-1:WIN_LSB] ==
                    TCM_BASE[IMEM_AWIDTH-1:WIN_LSB]);
    w_legal      = w_isRead & w_aligned & w_inWindow;

    sram_req_o   = core2imem_req_i & w_legal;
    sram_addr_o  = core2imem_addr_i[WIN_LSB-1:2];

    w_accept     = core2imem_req_i & (~w_legal | sram_gnt_i);
    imem2core_req_ack_o = w_accept;

    // A capture is allowed when nothing is latched yet, or when software is
    // clearing in this very cycle, so the newer fault replaces the old one.
    w_errCapture = w_accept & ~w_legal & (~r_errVld | err_clr_i);
  end

  // Response pipeline: one {vld, err} slot per cycle of SRAM latency. It
  // shifts unconditionally because the SRAM data cannot be held back, which
  // keeps OK and ER responses in strict acceptance order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pipeVld <= '0;
      r_pipeErr <= '0;
    end else begin
      r_pipeVld[0] <= w_accept;
      r_pipeErr[0] <= ~w_legal;
      for (int i = 1; i < READ_LAT; i++) begin
        r_pipeVld[i] <= r_pipeVld[i-1];
        r_pipeErr[i] <= r_pipeErr[i-1];
      end
    end
  end

  // Output stage. SRAM data is passed straight through on OK responses and
  // forced to zero otherwise, so stale SRAM contents never leak to the core.
  always_comb begin
    imem2core_resp_o  = SCR1_MEM_RESP_NOTRDY;
    imem2core_rdata_o = '0;
    if (r_pipeVld[READ_LAT-1]) begin
      if (r_pipeErr[READ_LAT-1]) begin
        imem2core_resp_o = SCR1_MEM_RESP_RDY_ER;
      end else begin
        imem2core_resp_o  = SCR1_MEM_RESP_RDY_OK;
        imem2core_rdata_o = sram_rdata_i;
      end
    end
  end

  // Sticky error record. The address stays frozen while the flag is set, so
  // software always sees the first fault since the last clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_errVld  <= 1'b0;
      r_errAddr <= '0;
    end else if (w_errCapture) begin
      r_errVld  <= 1'b1;
      r_errAddr <= core2imem_addr_i;
    end else if (err_clr_i) begin
      r_errVld  <= 1'b0;
    end
  end

  assign err_vld_o  = r_errVld;
  assign err_addr_o = r_errAddr;

endmodule

// File: tb/tb_scr1_imem_tcm_bridge.sv
// ---------------------------------------------------------------------------
// tb_scr1_imem_tcm_bridge
//
// Two bridges (READ_LAT = 2 and READ_LAT = 3) share one request stream. Each
// has its own SRAM model answering its own sram_addr_o. A reference model
// built from the bridge's externally visible rules (legality, acceptance
// history, latency, sticky error record) is compared against both every
// cycle. Directed sequences with hand-computed expectations are followed by
// a randomized phase.
// ---------------------------------------------------------------------------
module tb_scr1_imem_tcm_bridge;
  import scr1_memif_pkg::*;

  localparam int          MAXC = 4096;
  localparam logic [31:0] BASE = 32'hF000_0000;

  logic                clk = 1'b0;
  logic                rst;
  logic                req;
  type_scr1_mem_cmd_e  cmd;
  logic [31:0]         addr;
  logic                gnt;
  logic                clr;

  logic                ackA, ackB, sreqA, sreqB, evA, evB;
  logic [13:0]         saddrA, saddrB;
  logic [31:0]         rdA, rdB, sramA, sramB, eaA, eaB;
  type_scr1_mem_resp_e respA, respB;

  int passCount  = 0;
  int totalCount = 0;
  int cyc        = 0;
  int flushCyc   = -1;

  // Reference model state
  logic        accH   [MAXC];
  logic        errH   [MAXC];
  logic [31:0] addrH  [MAXC];
  logic        sramH  [MAXC];
  logic [13:0] sAddrA [MAXC];
  logic [13:0] sAddrB [MAXC];
  logic        mErrVld, nErrVld;
  logic [31:0] mErrAddr, nErrAddr;
  logic        expLegal, expAck, expSreq, expAcc;

  scr1_imem_tcm_bridge #(.READ_LAT(2)) dutA (
    .clk(clk), .rst(rst),
    .core2imem_req_i(req), .core2imem_cmd_i(cmd), .core2imem_addr_i(addr),
    .imem2core_req_ack_o(ackA), .imem2core_rdata_o(rdA), .imem2core_resp_o(respA),
    .sram_req_o(sreqA), .sram_addr_o(saddrA), .sram_gnt_i(gnt), .sram_rdata_i(sramA),
    .err_vld_o(evA), .err_addr_o(eaA), .err_clr_i(clr)
  );

  scr1_imem_tcm_bridge #(.READ_LAT(3)) dutB (
    .clk(clk), .rst(rst),
    .core2imem_req_i(req), .core2imem_cmd_i(cmd), .core2imem_addr_i(addr),
    .imem2core_req_ack_o(ackB), .imem2core_rdata_o(rdB), .imem2core_resp_o(respB),
    .sram_req_o(sreqB), .sram_addr_o(saddrB), .sram_gnt_i(gnt), .sram_rdata_i(sramB),
    .err_vld_o(evB), .err_addr_o(eaB), .err_clr_i(clr)
  );

  always #5 clk = ~clk;

  // Contents of the TCM as seen by the bench SRAM model
  function automatic logic [31:0] memWord(input logic [13:0] a);
    return ({18'h0, a} * 32'h9E37_79B1) ^ 32'hA5A5_0000;
  endfunction

  function automatic logic legalOf(input type_scr1_mem_cmd_e c, input logic [31:0] a);
    return (c == SCR1_MEM_CMD_RD) && (a[1:0] == 2'b00) && ((a >> 16) == (BASE >> 16));
  endfunction

  task automatic checkOutput(input string nm, input logic [31:0] act, input logic [31:0] exp);
    totalCount++;
    if (act === exp) passCount++;
    else $display("[TB] FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
  endtask

  // Expected response for a given latency from the acceptance history
  task automatic checkResp(input string nm, input int lat,
                           input type_scr1_mem_resp_e r, input logic [31:0] d);
    int                  idx;
    type_scr1_mem_resp_e expR;
    logic [31:0]         expD;
    idx  = cyc - lat;
    expR = SCR1_MEM_RESP_NOTRDY;
    expD = '0;
    if (idx >= 0 && idx > flushCyc && accH[idx]) begin
      if (errH[idx]) expR = SCR1_MEM_RESP_RDY_ER;
      else begin
        expR = SCR1_MEM_RESP_RDY_OK;
        expD = memWord(addrH[idx][15:2]);
      end
    end
    checkOutput({nm, "Resp"}, 32'(r), 32'(expR));
    checkOutput({nm, "Rdata"}, d, expD);
  endtask

  // Cycle advance: SRAM models return data for requests granted lat cycles ago
  always @(posedge clk) begin
    cyc = cyc + 1;
    mErrVld  = nErrVld;
    mErrAddr = nErrAddr;
    if (cyc >= 2 && sramH[cyc-2]) sramA = memWord(sAddrA[cyc-2]);
    else sramA = $urandom;
    if (cyc >= 3 && sramH[cyc-3]) sramB = memWord(sAddrB[cyc-3]);
    else sramB = $urandom;
  end

  // Per-cycle comparison against the reference model
  always @(negedge clk) begin
    expLegal = legalOf(cmd, addr);
    expAck   = req && (!expLegal || gnt);
    expSreq  = req && expLegal;
    checkOutput("ackA", 32'(ackA), 32'(expAck));
    checkOutput("ackB", 32'(ackB), 32'(expAck));
    checkOutput("sramReqA", 32'(sreqA), 32'(expSreq));
    checkOutput("sramReqB", 32'(sreqB), 32'(expSreq));
    if (expSreq) begin
      checkOutput("sramAddrA", 32'(saddrA), 32'(addr[15:2]));
      checkOutput("sramAddrB", 32'(saddrB), 32'(addr[15:2]));
    end
    sramH[cyc]  = sreqA && gnt;
    sAddrA[cyc] = saddrA;
    sAddrB[cyc] = saddrB;
    expAcc      = expAck && !rst;
    accH[cyc]   = expAcc;
    errH[cyc]   = !expLegal;
    addrH[cyc]  = addr;
    if (rst) begin
      flushCyc = cyc;
      mErrVld  = 1'b0;
      mErrAddr = '0;
    end
    checkResp("A", 2, respA, rdA);
    checkResp("B", 3, respB, rdB);
    checkOutput("errVldA", 32'(evA), 32'(mErrVld));
    checkOutput("errVldB", 32'(evB), 32'(mErrVld));
    checkOutput("errAddrA", eaA, mErrAddr);
    checkOutput("errAddrB", eaB, mErrAddr);
    nErrVld  = mErrVld;
    nErrAddr = mErrAddr;
    if (rst) begin
      nErrVld  = 1'b0;
      nErrAddr = '0;
    end else if (expAcc && !expLegal && (!mErrVld || clr)) begin
      nErrVld  = 1'b1;
      nErrAddr = addr;
    end else if (clr) begin
      nErrVld  = 1'b0;
    end
  end

  // Drive one cycle of core-side inputs, then stop at the sampling edge
  task automatic applyStimulus(input logic r, input type_scr1_mem_cmd_e c,
                               input logic [31:0] a, input logic g, input logic cl);
    @(posedge clk);
    #1;
    req  = r;
    cmd  = c;
    addr = a;
    gnt  = g;
    clr  = cl;
    @(negedge clk);
  endtask

  task automatic pulseReset();
    @(posedge clk);
    #1;
    rst = 1'b1;
    req = 1'b0;
    clr = 1'b0;
    @(negedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
  endtask

  logic [31:0]         mixAddr [4];
  type_scr1_mem_cmd_e  mixCmd  [4];
  type_scr1_mem_resp_e mixResp [4];
  int                  sramCnt;
  logic                nReq, nGnt, nClr;
  type_scr1_mem_cmd_e  nCmd;
  logic [31:0]         nAddr;
  int                  pick;

  initial begin
    for (int i = 0; i < MAXC; i++) begin
      accH[i] = 1'b0; errH[i] = 1'b0; addrH[i] = '0;
      sramH[i] = 1'b0; sAddrA[i] = '0; sAddrB[i] = '0;
    end
    mErrVld = 1'b0; mErrAddr = '0; nErrVld = 1'b0; nErrAddr = '0;
    rst = 1'b1; req = 1'b0; cmd = SCR1_MEM_CMD_RD; addr = '0; gnt = 1'b0; clr = 1'b0;
    sramA = '0; sramB = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    checkOutput("rstResp", 32'(respA), 32'(SCR1_MEM_RESP_NOTRDY));
    checkOutput("rstRdata", rdA, 32'h0);
    checkOutput("rstErrVld", 32'(evA), 32'h0);
    checkOutput("rstErrAddr", eaA, 32'h0);

    // Four back-to-back reads at the window base
    for (int i = 0; i < 6; i++) begin
      if (i < 4) applyStimulus(1'b1, SCR1_MEM_CMD_RD, BASE + 32'(4 * i), 1'b1, 1'b0);
      else       applyStimulus(1'b0, SCR1_MEM_CMD_RD, 32'h0, 1'b1, 1'b0);
      if (i < 4) checkOutput("b2bSramAddr", 32'(saddrA), 32'(i));
      if (i >= 2) begin
        checkOutput("b2bResp", 32'(respA), 32'(SCR1_MEM_RESP_RDY_OK));
        checkOutput("b2bRdata", rdA, memWord(14'(i - 2)));
      end
    end

    // Mixed legal/illegal stream
    mixAddr[0] = 32'hF000_0010; mixCmd[0] = SCR1_MEM_CMD_RD; mixResp[0] = SCR1_MEM_RESP_RDY_OK;
    mixAddr[1] = 32'hF000_0014; mixCmd[1] = SCR1_MEM_CMD_WR; mixResp[1] = SCR1_MEM_RESP_RDY_ER;
    mixAddr[2] = 32'hF000_0016; mixCmd[2] = SCR1_MEM_CMD_RD; mixResp[2] = SCR1_MEM_RESP_RDY_ER;
    mixAddr[3] = 32'hF000_0018; mixCmd[3] = SCR1_MEM_CMD_RD; mixResp[3] = SCR1_MEM_RESP_RDY_OK;
    sramCnt = 0;
    for (int i = 0; i < 6; i++) begin
      if (i < 4) applyStimulus(1'b1, mixCmd[i], mixAddr[i], 1'b1, 1'b0);
      else       applyStimulus(1'b0, SCR1_MEM_CMD_RD, 32'h0, 1'b1, 1'b0);
      if (i < 4 && sreqA) sramCnt++;
      if (i >= 2) begin
        checkOutput("mixResp", 32'(respA), 32'(mixResp[i-2]));
        if (mixResp[i-2] == SCR1_MEM_RESP_RDY_ER) checkOutput("mixErRdata", rdA, 32'h0);
      end
    end
    checkOutput("mixSramCnt", 32'(sramCnt), 32'd2);
    checkOutput("mixErrAddr", eaA, 32'hF000_0014);

    // Grant stall with the request held
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b1, SCR1_MEM_CMD_RD, 32'hF000_0020, 1'b0, 1'b0);
      checkOutput("stallAck", 32'(ackA), 32'h0);
      checkOutput("stallResp", 32'(respA), 32'(SCR1_MEM_RESP_NOTRDY));
    end
    applyStimulus(1'b1, SCR1_MEM_CMD_RD, 32'hF000_0020, 1'b1, 1'b0);
    checkOutput("stallAckGnt", 32'(ackA), 32'h1);
    applyStimulus(1'b0, SCR1_MEM_CMD_RD, 32'h0, 1'b0, 1'b0);
    applyStimulus(1'b0, SCR1_MEM_CMD_RD, 32'h0, 1'b0, 1'b0);
    checkOutput("stallResp", 32'(respA), 32'(SCR1_MEM_RESP_RDY_OK));
    checkOutput("stallRdata", rdA, memWord(14'd8));

    // Out-of-window access and error capture rules
    applyStimulus(1'b0, SCR1_MEM_CMD_RD, 32'h0, 1'b0, 1'b1);
    applyStimulus(1'b0, SCR1_MEM_CMD_RD, 32'h0, 1'b0, 1'b0);
    checkOutput("clrErrVld", 32'(evA), 32'h0);
    applyStimulus(1'b1, SCR1_MEM_CMD_RD, 32'h8000_0000, 1'b0, 1'b0);
    checkOutput("oowAck", 32'(ackA), 32'h1);
    applyStimulus(1'b0, SCR1_MEM_CMD_RD, 32'h0, 1'b0, 1'b0);
    checkOutput("oowErrVld", 32'(evA), 32'h1);
    checkOutput("oowErrAddr", eaA, 32'h8000_0000);
    applyStimulus(1'b1, SCR1_MEM_CMD_RD, 32'h8000_0004, 1'b1, 1'b0);
    checkOutput("oowResp", 32'(respA), 32'(SCR1_MEM_RESP_RDY_ER));
    applyStimulus(1'b0, SCR1_MEM_CMD_RD, 32'h0, 1'b0, 1'b0);
    checkOutput("frozenErrAddr", eaA, 32'h8000_0000);
    applyStimulus(1'b1, SCR1_MEM_CMD_RD, 32'h8000_0008, 1'b1, 1'b1);
    applyStimulus(1'b0, SCR1_MEM_CMD_RD, 32'h0, 1'b0, 1'b0);
    checkOutput("clrCapVld", 32'(evA), 32'h1);
    checkOutput("clrCapAddr", eaA, 32'h8000_0008);
    repeat (3) applyStimulus(1'b0, SCR1_MEM_CMD_RD, 32'h0, 1'b0, 1'b0);

    // Reset with two reads in flight on the latency-3 bridge
    applyStimulus(1'b1, SCR1_MEM_CMD_RD, 32'hF000_0030, 1'b1, 1'b0);
    applyStimulus(1'b1, SCR1_MEM_CMD_RD, 32'hF000_0034, 1'b1, 1'b0);
    pulseReset();
    checkOutput("rstFlushResp", 32'(respB), 32'(SCR1_MEM_RESP_NOTRDY));
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b0, SCR1_MEM_CMD_RD, 32'h0, 1'b1, 1'b0);
      checkOutput("rstFlushResp", 32'(respB), 32'(SCR1_MEM_RESP_NOTRDY));
    end
    applyStimulus(1'b1, SCR1_MEM_CMD_RD, 32'hF000_0040, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) applyStimulus(1'b0, SCR1_MEM_CMD_RD, 32'h0, 1'b1, 1'b0);
    checkOutput("postRstResp", 32'(respB), 32'(SCR1_MEM_RESP_RDY_OK));
    checkOutput("postRstRdata", rdB, memWord(14'd16));

    // Randomized traffic; a denied legal request is held stable
    for (int n = 0; n < 1500; n++) begin
      nGnt = ($urandom_range(0, 99) < 70);
      nClr = ($urandom_range(0, 99) < 5);
      if (req && legalOf(cmd, addr) && !gnt) begin
        nReq = req; nCmd = cmd; nAddr = addr;
      end else begin
        nReq = ($urandom_range(0, 99) < 80);
        nCmd = SCR1_MEM_CMD_RD;
        pick = $urandom_range(0, 99);
        if (pick < 70)      nAddr = {16'hF000, 14'($urandom), 2'b00};
        else if (pick < 80) nAddr = {16'hF000, 14'($urandom), 2'($urandom_range(1, 3))};
        else if (pick < 90) nAddr = $urandom;
        else begin
          nAddr = {16'hF000, 14'($urandom), 2'b00};
          nCmd  = SCR1_MEM_CMD_WR;
        end
      end
      if ($urandom_range(0, 299) == 0) pulseReset();
      else applyStimulus(nReq, nCmd, nAddr, nGnt, nClr);
    end
    repeat (4) applyStimulus(1'b0, SCR1_MEM_CMD_RD, 32'h0, 1'b0, 1'b0);

    $display("%0d/%0d checks passed", passCount, totalCount);
    $finish;
  end

endmodule
